// File: rtl/param_register_file.sv
// Parameterised register file with a self-initialising sweep.
// After reset (or a clear request) the file walks every register and
// loads a seed value, then enters RUN and behaves as a two-read,
// one-write register file with write-first bypass on the read ports.
module param_register_file #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned INIT_MODE = 1,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  input  logic [ADDR_W-1:0] Rd,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              ClearReq,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Ready
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic                user_wr;

  // Seed value loaded into register idx during the sweep.
  function automatic logic [DATA_W-1:0] seed_value(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    if (INIT_MODE == 1) begin
      v = DATA_W'(idx);
    end
    return v;
  endfunction

  // True when addr is the hardwired-zero register.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG == 1) && (addr == '0);
  endfunction

  // A user write that actually lands (RUN only, register 0 suppressed).
  assign user_wr = (state_q == RUN) && RegWrite && !is_zero_reg(Rd);

  // FSM state, sweep counter and Ready register; reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic: sweep in INIT, leave on the last register, ClearReq restarts from RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    unique case (state_q)
      INIT: begin
        ready_d = 1'b0;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d   = '0;
        ready_d = 1'b1;
        if (ClearReq) begin
          state_d = INIT;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Single write port shared by the sweep (INIT) and user writes (RUN).
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (state_q == INIT) begin
      we    = !is_zero_reg(cnt_q);
      waddr = cnt_q;
      wdata = seed_value(cnt_q);
    end else if (user_wr) begin
      we    = 1'b1;
      waddr = Rd;
      wdata = WriteData;
    end
  end

  // Storage array; contents are not reset, the sweep initialises them.
  always_ff @(posedge clk) begin
    if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Combinational read port 1 with zero-register, bypass and not-ready gating.
  always_comb begin
    ReadData1 = '0;
    if (ready_q && !is_zero_reg(Rs1)) begin
      if (user_wr && (Rd == Rs1)) begin
        ReadData1 = WriteData;
      end else begin
        ReadData1 = regs_q[Rs1];
      end
    end
  end

  // Combinational read port 2 with zero-register, bypass and not-ready gating.
  always_comb begin
    ReadData2 = '0;
    if (ready_q && !is_zero_reg(Rs2)) begin
      if (user_wr && (Rd == Rs2)) begin
        ReadData2 = WriteData;
      end else begin
        ReadData2 = regs_q[Rs2];
      end
    end
  end

  assign Ready = ready_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file (64-bit, 32 registers, index seed, zero reg).
module tb_param_register_file;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] Rs1;
  logic [ADDR_W-1:0] Rs2;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic              ClearReq;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Ready;

  int checks;
  int failures;

  param_register_file #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_MODE(1),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Rs1      (Rs1),
    .Rs2      (Rs2),
    .Rd       (Rd),
    .WriteData(WriteData),
    .RegWrite (RegWrite),
    .ClearReq (ClearReq),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2),
    .Ready    (Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d required completion", checks);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; RegWrite = 1'b0; ClearReq = 1'b0;
    Rd = '0; WriteData = '0; Rs1 = 5'd7; Rs2 = 5'd31;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (Ready !== 1'b0 || ReadData1 !== '0 || ReadData2 !== '0) begin
      failures++;
      $display("FAIL reset_state: Ready=%b RD1=%h RD2=%h required 0 0 0", Ready, ReadData1, ReadData2);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      checks++;
      if (Ready !== (i == 32)) begin
        failures++;
        $display("FAIL reset_sweep_ready edge %0d: Ready=%b required %b", i, Ready, (i == 32));
      end
    end
    @(negedge clk);
    checks++;
    if (ReadData1 !== 64'd7 || ReadData2 !== 64'd31) begin
      failures++;
      $display("FAIL seed_read: RD1=%h RD2=%h required 7 1f", ReadData1, ReadData2);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    RegWrite = 1'b1; Rd = 5'd5; WriteData = 64'hDEAD; Rs1 = 5'd5; Rs2 = 5'd6;
    #1;
    checks++;
    if (ReadData1 !== 64'hDEAD || ReadData2 !== 64'd6) begin
      failures++;
      $display("FAIL bypass_same_cycle: RD1=%h RD2=%h required dead 6", ReadData1, ReadData2);
    end
    @(posedge clk); #1;
    RegWrite = 1'b0; WriteData = 64'h1234;
    #1;
    checks++;
    if (ReadData1 !== 64'hDEAD) begin
      failures++;
      $display("FAIL bypass_stored: RD1=%h required dead", ReadData1);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    RegWrite = 1'b1; Rd = 5'd0; WriteData = 64'hFF; Rs1 = 5'd0; Rs2 = 5'd0;
    #1;
    checks++;
    if (ReadData1 !== '0 || ReadData2 !== '0) begin
      failures++;
      $display("FAIL zero_reg_bypass: RD1=%h RD2=%h required 0 0", ReadData1, ReadData2);
    end
    @(posedge clk); #1;
    RegWrite = 1'b0;
    #1;
    checks++;
    if (ReadData1 !== '0) begin
      failures++;
      $display("FAIL zero_reg_stored: RD1=%h required 0", ReadData1);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    RegWrite = 1'b1; Rd = 5'd1; WriteData = 64'h1111_0000_0000_0001; Rs1 = 5'd1; Rs2 = 5'd2;
    @(negedge clk);
    Rd = 5'd2; WriteData = 64'h2222; Rs1 = 5'd1; Rs2 = 5'd2;
    #1;
    checks++;
    if (ReadData1 !== 64'h1111_0000_0000_0001 || ReadData2 !== 64'h2222) begin
      failures++;
      $display("FAIL b2b_write2: RD1=%h RD2=%h required 1111000000000001 2222", ReadData1, ReadData2);
    end
    @(negedge clk);
    Rd = 5'd3; WriteData = 64'h3333; Rs1 = 5'd2; Rs2 = 5'd3;
    #1;
    checks++;
    if (ReadData1 !== 64'h2222 || ReadData2 !== 64'h3333) begin
      failures++;
      $display("FAIL b2b_write3: RD1=%h RD2=%h required 2222 3333", ReadData1, ReadData2);
    end
    @(negedge clk);
    RegWrite = 1'b0; Rs1 = 5'd3; Rs2 = 5'd4;
    #1;
    checks++;
    if (ReadData1 !== 64'h3333 || ReadData2 !== 64'd4) begin
      failures++;
      $display("FAIL b2b_readback: RD1=%h RD2=%h required 3333 4", ReadData1, ReadData2);
    end
  endtask

  task automatic test_init_ignore();
    // Re-enter INIT via reset, then hammer RegWrite and ClearReq during the sweep.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; RegWrite = 1'b1; Rd = 5'd3; WriteData = 64'h55; Rs1 = 5'd3; Rs2 = 5'd3;
    for (int i = 1; i <= 32; i++) begin
      ClearReq = (i >= 5 && i <= 20);
      @(posedge clk); #1;
      checks++;
      if (Ready !== (i == 32)) begin
        failures++;
        $display("FAIL init_ignore_ready edge %0d: Ready=%b required %b", i, Ready, (i == 32));
      end
      if (i < 32) begin
        checks++;
        if (ReadData1 !== '0) begin
          failures++;
          $display("FAIL init_outputs_zero edge %0d: RD1=%h required 0", i, ReadData1);
        end
      end
    end
    RegWrite = 1'b0; ClearReq = 1'b0;
    #1;
    checks++;
    if (ReadData1 !== 64'd3) begin
      failures++;
      $display("FAIL init_write_ignored: RD1=%h required 3", ReadData1);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    RegWrite = 1'b1; Rd = 5'd9; WriteData = 64'hAA; Rs1 = 5'd9; Rs2 = 5'd12;
    @(negedge clk);
    RegWrite = 1'b0;
    #1;
    checks++;
    if (ReadData1 !== 64'hAA) begin
      failures++;
      $display("FAIL clear_prewrite: RD1=%h required aa", ReadData1);
    end
    @(negedge clk);
    ClearReq = 1'b1; RegWrite = 1'b1; Rd = 5'd12; WriteData = 64'h77;
    #1;
    checks++;
    if (ReadData2 !== 64'h77 || Ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_cycle_bypass: RD2=%h Ready=%b required 77 1", ReadData2, Ready);
    end
    @(posedge clk); #1;
    ClearReq = 1'b0; RegWrite = 1'b0;
    checks++;
    if (Ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_ready_fall: Ready=%b required 0", Ready);
    end
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      checks++;
      if (Ready !== (i == 32)) begin
        failures++;
        $display("FAIL clear_sweep_ready edge %0d: Ready=%b required %b", i, Ready, (i == 32));
      end
      if (i < 32) begin
        checks++;
        if (ReadData1 !== '0 || ReadData2 !== '0) begin
          failures++;
          $display("FAIL clear_outputs_zero edge %0d: RD1=%h RD2=%h required 0 0", i, ReadData1, ReadData2);
        end
      end
    end
    #1;
    checks++;
    if (ReadData1 !== 64'd9 || ReadData2 !== 64'd12) begin
      failures++;
      $display("FAIL clear_reseeded: RD1=%h RD2=%h required 9 c", ReadData1, ReadData2);
    end
  endtask

  task automatic test_async_reset();
    // Reset in RUN during a bypassed write: outputs drop with no clock edge.
    @(negedge clk);
    RegWrite = 1'b1; Rd = 5'd7; WriteData = 64'hBEEF; Rs1 = 5'd7; Rs2 = 5'd8;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if (Ready !== 1'b0 || ReadData1 !== '0 || ReadData2 !== '0) begin
      failures++;
      $display("FAIL async_reset_run: Ready=%b RD1=%h RD2=%h required 0 0 0", Ready, ReadData1, ReadData2);
    end
    @(negedge clk);
    reset = 1'b0; RegWrite = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (Ready !== 1'b0 || ReadData1 !== '0) begin
      failures++;
      $display("FAIL async_reset_sweep: Ready=%b RD1=%h required 0 0", Ready, ReadData1);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      checks++;
      if (Ready !== (i == 32)) begin
        failures++;
        $display("FAIL async_reset_resweep edge %0d: Ready=%b required %b", i, Ready, (i == 32));
      end
    end
    #1;
    checks++;
    if (ReadData1 !== 64'd7 || ReadData2 !== 64'd8) begin
      failures++;
      $display("FAIL async_reset_reseeded: RD1=%h RD2=%h required 7 8", ReadData1, ReadData2);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_back_to_back();
    test_init_ignore();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter: DATA_W, 64, data width in bits.
REQ-002 Parameter: ADDR_W, 5, address width; register count NUM_REGS = 2**ADDR_W.
REQ-003 Parameter: INIT_MODE, 1, sweep value: 1 = register i loads i (zero-extended), 0 = all registers load 0.
REQ-004 Parameter: ZERO_REG, 1, 1 = register 0 is hardwired to zero and never written.
REQ-005 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-high reset.
REQ-007 Port: Rs1  input  ADDR_W  read address, port 1.
REQ-008 Port: Rs2  input  ADDR_W  read address, port 2.
REQ-009 Port: Rd  input  ADDR_W  write address.
REQ-010 Port: WriteData  input  DATA_W  write data.
REQ-011 Port: RegWrite  input  1  write enable.
REQ-012 Port: ClearReq  input  1  request re-initialisation sweep.
REQ-013 Port: ReadData1  output  DATA_W  read data, port 1.
REQ-014 Port: ReadData2  output  DATA_W  read data, port 2.
REQ-015 Port: Ready  output  1  high when register file is in RUN state.

Function
REQ-016 The block SHALL implement a two-state FSM, INIT and RUN, plus an ADDR_W-bit sweep counter.
REQ-017 INIT: each rising edge SHALL write the INIT_MODE value to the register at the counter, then increment the counter.
REQ-018 INIT SHALL transition to RUN on the edge that writes register NUM_REGS-1; Ready SHALL be registered and rise on that same edge (NUM_REGS edges after reset release).
REQ-019 RegWrite SHALL be ignored in INIT; ClearReq SHALL be ignored in INIT (sweep neither restarts nor extends).
REQ-020 RUN: on a rising edge with RegWrite=1, WriteData SHALL be stored at Rd, except Rd=0 when ZERO_REG=1.
REQ-021 RUN: ClearReq=1 SHALL move the FSM to INIT with counter 0 on the next edge; Ready SHALL fall on that edge; a simultaneous RegWrite SHALL still be performed on that edge (the sweep later overwrites it).
REQ-022 Reads SHALL be combinational, zero-latency from Rs1/Rs2.
REQ-023 Write-first bypass: in RUN, if RegWrite=1 and Rd equals a read address (and is not a suppressed register 0), that port SHALL return WriteData in the same cycle.
REQ-024 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of bypass.
REQ-025 While Ready=0 (INIT or reset), ReadData1 and ReadData2 SHALL be 0.
REQ-026 The counter SHALL not wrap past NUM_REGS-1 in INIT; in RUN it SHALL hold 0.

Reset
REQ-027 Asserting reset SHALL immediately force state INIT, counter 0, Ready=0, ReadData1=ReadData2=0, including mid-sweep or mid-write.
REQ-028 Register contents need not be reset directly; after release the sweep SHALL restart from register 0 and complete a full NUM_REGS-cycle sweep.

Verification (DATA_W=64, ADDR_W=5, INIT_MODE=1, ZERO_REG=1)
REQ-029 Reset pulse then release -> Ready=0 for 31 edges, rises on edge 32; then Rs1=7, Rs2=31 -> ReadData1=7, ReadData2=31.
REQ-030 RUN, RegWrite=1, Rd=5, WriteData=0xDEAD, Rs1=5 -> ReadData1=0xDEAD same cycle; after edge, RegWrite=0 -> ReadData1 still 0xDEAD.
REQ-031 RUN, RegWrite=1, Rd=0, WriteData=0xFF, Rs1=0 -> ReadData1=0 before and after edge.
REQ-032 During INIT, RegWrite=1, Rd=3, WriteData=0x55 -> after Ready, Rs1=3 reads 3.
REQ-033 RUN, write 0xAA to reg 9, then ClearReq=1 for one cycle -> Ready falls next edge, outputs 0 for 32 edges, Ready returns, Rs1=9 reads 9.
REQ-034 Reset asserted asynchronously at sweep count 10 -> outputs 0 and Ready=0 without clock edge; after release Ready rises exactly 32 edges later.
